// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches over imem req/ack, hands instructions to decode via valid/ready.
// Best case one instruction per two cycles; a misaligned redirect parks the unit in HALT until reset.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_code,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        fetch_fault,
  output logic [31:0] fault_addr,
  output logic [31:0] instret
);

  typedef enum logic [1:0] {BOOT, FETCH, VALID, HALT} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic        imem_req_q;
  logic [31:0] imem_addr_q;
  logic [31:0] instr_code_q;
  logic [31:0] instr_pc_q;
  logic        instr_valid_q;
  logic        fetch_fault_q;
  logic [31:0] fault_addr_q;
  logic [31:0] instret_q;

  logic [31:0] pc_d;
  logic        misaligned;

  // Sequential successor wraps naturally at 2^32.
  assign pc_d       = redirect_valid ? redirect_target : instr_pc_q + 32'd4;
  assign misaligned = redirect_valid && (redirect_target[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= RESET_PC;
      instr_code_q  <= NOP_INSTR;
      instr_pc_q    <= RESET_PC;
      instr_valid_q <= 1'b0;
      fetch_fault_q <= 1'b0;
      fault_addr_q  <= 32'h0;
      instret_q     <= 32'h0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q     <= FETCH;
          imem_req_q  <= 1'b1;
          imem_addr_q <= pc_q;
        end
        FETCH: begin
          if (imem_ack) begin
            state_q       <= VALID;
            imem_req_q    <= 1'b0;
            instr_code_q  <= imem_rdata;
            instr_pc_q    <= pc_q;
            instr_valid_q <= 1'b1;
          end
        end
        VALID: begin
          if (instr_ready) begin
            instret_q     <= instret_q + 32'd1;
            instr_valid_q <= 1'b0;
            instr_code_q  <= NOP_INSTR;
            if (misaligned) begin
              state_q       <= HALT;
              fetch_fault_q <= 1'b1;
              fault_addr_q  <= redirect_target;
            end else begin
              state_q     <= FETCH;
              pc_q        <= pc_d;
              imem_req_q  <= 1'b1;
              imem_addr_q <= pc_d;
            end
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          state_q <= HALT;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instr_code  = instr_code_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign fetch_fault = fetch_fault_q;
  assign fault_addr  = fault_addr_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; memory returns addr + 0x1000_0000 so expected codes are easy to derive.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Main instance, RESET_PC = 0
  logic        rst;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instr_code, instr_pc;
  logic        instr_valid, instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        fetch_fault;
  logic [31:0] fault_addr, instret;
  logic        auto_ack;

  assign imem_ack   = auto_ack & imem_req;
  assign imem_rdata = imem_addr + 32'h1000_0000;

  instr_fetch_unit u_dut (
    .clk(clk), .reset(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_code(instr_code), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .fetch_fault(fetch_fault), .fault_addr(fault_addr), .instret(instret)
  );

  // Second instance at the top of the address space; ack held high to show it is ignored outside FETCH
  logic        rst2;
  logic        h_req;
  logic [31:0] h_addr, h_rdata, h_code, h_pc, h_faddr, h_instret;
  logic        h_valid, h_fault;

  assign h_rdata = h_addr + 32'h1000_0000;

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_hi (
    .clk(clk), .reset(rst2),
    .imem_req(h_req), .imem_addr(h_addr), .imem_ack(1'b1), .imem_rdata(h_rdata),
    .instr_code(h_code), .instr_pc(h_pc), .instr_valid(h_valid), .instr_ready(1'b1),
    .redirect_valid(1'b0), .redirect_target(32'h0),
    .fetch_fault(h_fault), .fault_addr(h_faddr), .instret(h_instret)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    auto_ack = 1'b1; instr_ready = 1'b1;
    redirect_valid = 1'b0; redirect_target = 32'h0;
    step(); step();

    chk("rst_req",     {31'd0, imem_req},    32'd0);
    chk("rst_addr",    imem_addr,            32'h0);
    chk("rst_code",    instr_code,           32'h0000_0013);
    chk("rst_pc",      instr_pc,             32'h0);
    chk("rst_valid",   {31'd0, instr_valid}, 32'd0);
    chk("rst_fault",   {31'd0, fetch_fault}, 32'd0);
    chk("rst_faddr",   fault_addr,           32'h0);
    chk("rst_instret", instret,              32'h0);

    // Streaming with 1-cycle memory and decode always ready
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("seq_req",   {31'd0, imem_req},    32'd1);
      chk("seq_addr",  imem_addr,            32'(4 * i));
      chk("seq_nv",    {31'd0, instr_valid}, 32'd0);
      chk("seq_ret",   instret,              32'(i));
      step();
      chk("seq_valid", {31'd0, instr_valid}, 32'd1);
      chk("seq_pc",    instr_pc,             32'(4 * i));
      chk("seq_code",  instr_code,           32'h1000_0000 + 32'(4 * i));
    end

    // Slow memory: request held for three cycles, data captured on the fourth edge
    auto_ack = 1'b0;
    step();
    chk("ret3", instret, 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("slow_req",  {31'd0, imem_req},    32'd1);
      chk("slow_addr", imem_addr,            32'h0000_000C);
      chk("slow_nv",   {31'd0, instr_valid}, 32'd0);
      step();
    end
    auto_ack = 1'b1;
    instr_ready = 1'b0;
    chk("slow_addr3", imem_addr, 32'h0000_000C);
    step();
    chk("slow_code", instr_code, 32'h1000_000C);
    chk("slow_pc",   instr_pc,   32'h0000_000C);

    // Decode stalls for five cycles
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_code",  instr_code,           32'h1000_000C);
      chk("stall_pc",    instr_pc,             32'h0000_000C);
      chk("stall_req",   {31'd0, imem_req},    32'd0);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_ret",   instret,              32'd3);
    end

    // Retire 0xC sequentially, then redirect from 0x10 to 0x100
    instr_ready = 1'b1;
    step();
    chk("r_addr10", imem_addr, 32'h0000_0010);
    chk("r_nop",    instr_code, 32'h0000_0013);
    instr_ready = 1'b0;
    step();
    chk("r_pc10", instr_pc, 32'h0000_0010);
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_0100;
    step();
    redirect_valid = 1'b0;
    chk("br_addr", imem_addr, 32'h0000_0100);
    chk("br_req",  {31'd0, imem_req}, 32'd1);
    chk("br_ret",  instret, 32'd5);
    instr_ready = 1'b0;
    step();
    chk("br_pc",   instr_pc,   32'h0000_0100);
    chk("br_code", instr_code, 32'h1000_0100);

    // Misaligned redirect halts and records the target
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_0102;
    step();
    redirect_valid = 1'b0;
    chk("flt_fault", {31'd0, fetch_fault}, 32'd1);
    chk("flt_addr",  fault_addr,           32'h0000_0102);
    chk("flt_ret",   instret,              32'd6);
    chk("flt_valid", {31'd0, instr_valid}, 32'd0);
    chk("flt_code",  instr_code,           32'h0000_0013);
    for (int i = 0; i < 8; i++) begin
      chk("halt_req", {31'd0, imem_req}, 32'd0);
      step();
    end
    chk("halt_fault", {31'd0, fetch_fault}, 32'd1);

    #2 rst = 1'b1;
    #1;
    chk("clr_fault", {31'd0, fetch_fault}, 32'd0);
    chk("clr_faddr", fault_addr,           32'h0);
    chk("clr_ret",   instret,              32'h0);

    // Wrap from 0xFFFF_FFFC to 0, then reset in the middle of a fetch
    rst2 = 1'b0;
    step();
    chk("hi_req",  {31'd0, h_req}, 32'd1);
    chk("hi_addr", h_addr,         32'hFFFF_FFFC);
    step();
    chk("hi_pc",   h_pc,   32'hFFFF_FFFC);
    chk("hi_code", h_code, 32'h0FFF_FFFC);
    step();
    chk("hi_wrap", h_addr,    32'h0000_0000);
    chk("hi_ret",  h_instret, 32'd1);
    chk("hi_req2", {31'd0, h_req}, 32'd1);
    #3 rst2 = 1'b1;
    #1;
    chk("mid_req",   {31'd0, h_req},   32'd0);
    chk("mid_addr",  h_addr,           32'hFFFF_FFFC);
    chk("mid_valid", {31'd0, h_valid}, 32'd0);
    step();
    chk("mid_hold_req", {31'd0, h_req}, 32'd0);
    chk("mid_hold_pc",  h_pc,           32'hFFFF_FFFC);
    rst2 = 1'b0;
    step();
    chk("restart_req",   {31'd0, h_req},   32'd1);
    chk("restart_addr",  h_addr,           32'hFFFF_FFFC);
    chk("restart_valid", {31'd0, h_valid}, 32'd0);
    chk("hi_nofault",    {31'd0, h_fault}, 32'd0);
    chk("hi_nofaddr",    h_faddr,          32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
